tlul_outstanding_limiter: RTL and testbench

// Host-side stage placed directly upstream of the TL-UL async FIFO crossing. Caps the number
// of in-flight TL-UL requests, tracks their a_source IDs in order, and checks every D response

---
 rtl/tlul_outstanding_limiter_pkg.sv | 52 +++++
 rtl/tlul_outstanding_limiter_if.sv | 10 +
 rtl/tlul_outstanding_limiter_fifo.sv | 71 +++++++
 rtl/tlul_outstanding_limiter.sv | 101 ++++++++++
 tb/tb_tlul_outstanding_limiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/tlul_outstanding_limiter_pkg.sv
// TL-UL channel types and helpers shared by the outstanding-request limiter, its
// source-ID FIFO and the bus interface.
package tlul_outstanding_limiter_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

    // Width needed to hold a count in the range 0..max inclusive.
    function automatic int cnt_width(int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/tlul_outstanding_limiter_if.sv
// One TL-UL link (request + response structs) with host/device views.
interface tlul_outstanding_limiter_if;
    import tlul_outstanding_limiter_pkg::*;

    tl_h2d_t h2d;
    tl_d2h_t d2h;

    modport host   (output h2d, input  d2h);
    modport device (input  h2d, output d2h);
endinterface

// File: rtl/tlul_outstanding_limiter_fifo.sv
// Synchronous FIFO with show-ahead read; Pass=1 lets a write bypass an empty FIFO.
module prim_fifo_sync #(
    parameter  int Width  = 8,
    parameter  int Depth  = 4,
    parameter  bit Pass   = 1'b0,
    localparam int DepthW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic [DepthW-1:0] depth_o
);
    localparam int               PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0]  LastPtr = PtrW'(Depth - 1);

    logic [Width-1:0]  mem [Depth];
    logic [PtrW-1:0]   wptr_reg, wptr_next, rptr_reg, rptr_next;
    logic [DepthW-1:0] depth_reg, depth_next;
    logic              empty, full, bypass, push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (depth_reg == '0);
    assign full     = (depth_reg == DepthW'(Depth));
    assign bypass   = Pass & empty & wvalid_i;
    assign wready_o = ~full;
    assign rvalid_o = ~empty | bypass;
    assign rdata_o  = bypass ? wdata_i : mem[rptr_reg];
    assign depth_o  = depth_reg;

    // A bypassed word that is consumed immediately never touches storage.
    assign push = wvalid_i & ~full & ~(bypass & rready_i);
    assign pop  = rvalid_o & rready_i & ~bypass;

    always_comb begin
        wptr_next  = push ? ptr_inc(wptr_reg) : wptr_reg;
        rptr_next  = pop  ? ptr_inc(rptr_reg) : rptr_reg;
        depth_next = depth_reg;
        case ({push, pop})
            2'b10:   depth_next = depth_reg + 1'b1;
            2'b01:   depth_next = depth_reg - 1'b1;
            default: depth_next = depth_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            depth_reg <= '0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            depth_reg <= depth_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr_reg] <= wdata_i;
        end
    end

endmodule

// File: rtl/tlul_outstanding_limiter.sv
// Caps in-flight TL-UL requests ahead of the async crossing, checks response IDs in
// order against the requests issued, and offers a drain/idle quiesce handshake.
module tlul_outstanding_limiter
    import tlul_outstanding_limiter_pkg::*;
#(
    parameter  int MaxOutstanding = 4,
    parameter  bit CheckSource    = 1'b1,
    localparam int CntW           = cnt_width(MaxOutstanding)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  tl_h2d_t         tl_h_i,
    output tl_d2h_t         tl_h_o,
    output tl_h2d_t         tl_d_o,
    input  tl_d2h_t         tl_d_i,
    input  logic            drain_i,
    output logic            idle_o,
    output logic [CntW-1:0] outstanding_o,
    output logic            err_o,
    input  logic            err_clr_i
);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    logic [CntW-1:0]   cnt_reg, cnt_next;
    logic              a_pend_reg, a_pend_next;
    logic              err_reg, err_next;
    logic              block, a_acc, d_acc, d_exp, d_unexp, id_bad;
    logic              fifo_wready, fifo_rvalid;
    logic [TL_AIW-1:0] head_id;
    logic [CntW-1:0]   fifo_depth;

    // An offered beat keeps drain from blocking, so valid is never retracted.
    assign block = (cnt_reg == CntMax) | (drain_i & ~a_pend_reg);

    always_comb begin
        tl_d_o         = tl_h_i;
        tl_d_o.a_valid = tl_h_i.a_valid & ~block;
        tl_h_o         = tl_d_i;
        tl_h_o.a_ready = tl_d_i.a_ready & ~block;
    end

    assign a_acc   = tl_d_o.a_valid & tl_d_i.a_ready;
    assign d_acc   = tl_d_i.d_valid & tl_h_i.d_ready;
    assign d_exp   = d_acc & (cnt_reg != '0);
    assign d_unexp = d_acc & (cnt_reg == '0);
    assign id_bad  = CheckSource & (~fifo_rvalid | (tl_d_i.d_source != head_id));

    always_comb begin
        cnt_next = cnt_reg;
        case ({a_acc, d_exp})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase
        a_pend_next = tl_d_o.a_valid & ~tl_d_i.a_ready;
        err_next    = err_reg;
        if (d_unexp | (d_exp & id_bad)) begin
            err_next = 1'b1;
        end else if (err_clr_i) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg    <= '0;
            a_pend_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            a_pend_reg <= a_pend_next;
            err_reg    <= err_next;
        end
    end

    prim_fifo_sync #(
        .Width (TL_AIW),
        .Depth (MaxOutstanding),
        .Pass  (1'b0)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wvalid_i (a_acc),
        .wready_o (fifo_wready),
        .wdata_i  (tl_h_i.a_source),
        .rvalid_o (fifo_rvalid),
        .rready_i (d_exp),
        .rdata_o  (head_id),
        .depth_o  (fifo_depth)
    );

    assign idle_o        = (cnt_reg == '0) & ~a_pend_reg;
    assign outstanding_o = cnt_reg;
    assign err_o         = err_reg;

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_reg <= CntMax);
    a_fifo_track: assert property (@(posedge clk_i) disable iff (!rst_ni) fifo_depth == cnt_reg);
    a_push_room: assert property (@(posedge clk_i) disable iff (!rst_ni) a_acc |-> fifo_wready);
    a_valid_hold: assert property (@(posedge clk_i) disable iff (!rst_ni) a_pend_reg |-> tl_h_i.a_valid);

endmodule

// File: tb/tb_tlul_outstanding_limiter.sv
// Directed scenarios for the outstanding-request limiter with hand-computed expectations.
module tb_tlul_outstanding_limiter;
    import tlul_outstanding_limiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       drain;
    logic       err_clr;
    logic       idle;
    logic       err;
    logic [2:0] outstanding;
    int         assertions = 0;
    int         failures   = 0;

    tlul_outstanding_limiter_if host_bus ();
    tlul_outstanding_limiter_if dev_bus ();

    always #5 clk = ~clk;

    tlul_outstanding_limiter #(
        .MaxOutstanding (4),
        .CheckSource    (1'b1)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .tl_h_i        (host_bus.h2d),
        .tl_h_o        (host_bus.d2h),
        .tl_d_o        (dev_bus.h2d),
        .tl_d_i        (dev_bus.d2h),
        .drain_i       (drain),
        .idle_o        (idle),
        .outstanding_o (outstanding),
        .err_o         (err),
        .err_clr_i     (err_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] src);
        host_bus.h2d.a_valid  = 1'b1;
        host_bus.h2d.a_source = src;
        host_bus.h2d.a_opcode = Get;
        dev_bus.d2h.a_ready   = 1'b1;
        step();
        host_bus.h2d.a_valid  = 1'b0;
        $display("req  src=%0d outstanding=%0d", src, outstanding);
    endtask

    task automatic respond(input logic [7:0] src);
        dev_bus.d2h.d_valid  = 1'b1;
        dev_bus.d2h.d_source = src;
        host_bus.h2d.d_ready = 1'b1;
        step();
        dev_bus.d2h.d_valid  = 1'b0;
        $display("rsp  src=%0d outstanding=%0d err=%0d", src, outstanding, err);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni       = 1'b0;
        drain        = 1'b0;
        err_clr      = 1'b0;
        host_bus.h2d = '0;
        dev_bus.d2h  = '0;
        repeat (3) @(posedge clk);
        #1;
        assertions++; if (outstanding !== 3'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", outstanding); end
        assertions++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %0b expected 1", idle); end
        assertions++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b expected 0", err); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_fill();
        host_bus.h2d.a_valid = 1'b1;
        host_bus.h2d.a_opcode = Get;
        dev_bus.d2h.a_ready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_bus.h2d.a_source = 8'(i);
            #1;
            assertions++;
            if (host_bus.d2h.a_ready !== (i < 4)) begin
                failures++; $display("FAIL fill_ready[%0d]: got %0b expected %0b", i, host_bus.d2h.a_ready, i < 4);
            end
            assertions++;
            if (dev_bus.h2d.a_valid !== (i < 4)) begin
                failures++; $display("FAIL fill_valid[%0d]: got %0b expected %0b", i, dev_bus.h2d.a_valid, i < 4);
            end
            step();
            $display("fill beat %0d outstanding=%0d", i, outstanding);
        end
        host_bus.h2d.a_valid = 1'b0;
        assertions++; if (outstanding !== 3'd4) begin failures++; $display("FAIL fill_cnt: got %0d expected 4", outstanding); end
        for (int i = 0; i < 4; i++) respond(8'(i));
        assertions++; if (outstanding !== 3'd0 || err !== 1'b0) begin failures++; $display("FAIL fill_drain: got cnt=%0d err=%0b expected cnt=0 err=0", outstanding, err); end
    endtask

    task automatic test_in_order();
        logic [7:0] ids [3];
        ids[0] = 8'd3; ids[1] = 8'd7; ids[2] = 8'd1;
        for (int i = 0; i < 3; i++) send(ids[i]);
        assertions++; if (outstanding !== 3'd3) begin failures++; $display("FAIL inorder_cnt3: got %0d expected 3", outstanding); end
        for (int i = 0; i < 3; i++) begin
            respond(ids[i]);
            assertions++;
            if (outstanding !== 3'(2 - i)) begin failures++; $display("FAIL inorder_step[%0d]: got %0d expected %0d", i, outstanding, 2 - i); end
        end
        assertions++; if (err !== 1'b0) begin failures++; $display("FAIL inorder_err: got %0b expected 0", err); end
        assertions++; if (idle !== 1'b1) begin failures++; $display("FAIL inorder_idle: got %0b expected 1", idle); end
    endtask

    task automatic test_mismatch();
        send(8'd3);
        send(8'd7);
        respond(8'd7);
        assertions++; if (err !== 1'b1) begin failures++; $display("FAIL mismatch_err: got %0b expected 1", err); end
        assertions++; if (outstanding !== 3'd1) begin failures++; $display("FAIL mismatch_cnt: got %0d expected 1", outstanding); end
        pulse_clr();
        assertions++; if (err !== 1'b0) begin failures++; $display("FAIL mismatch_clr: got %0b expected 0", err); end
        respond(8'd7);
        assertions++; if (err !== 1'b0 || outstanding !== 3'd0) begin failures++; $display("FAIL mismatch_tail: got err=%0b cnt=%0d expected err=0 cnt=0", err, outstanding); end
    endtask

    task automatic test_unexpected();
        host_bus.h2d.a_valid  = 1'b1;
        host_bus.h2d.a_source = 8'd5;
        dev_bus.d2h.a_ready   = 1'b1;
        dev_bus.d2h.d_valid   = 1'b1;
        dev_bus.d2h.d_source  = 8'd5;
        host_bus.h2d.d_ready  = 1'b1;
        step();
        host_bus.h2d.a_valid = 1'b0;
        dev_bus.d2h.d_valid  = 1'b0;
        $display("unexpected rsp with req src=5 outstanding=%0d err=%0b", outstanding, err);
        assertions++; if (err !== 1'b1) begin failures++; $display("FAIL unexp_err: got %0b expected 1", err); end
        assertions++; if (outstanding !== 3'd1) begin failures++; $display("FAIL unexp_cnt: got %0d expected 1", outstanding); end
        pulse_clr();
        respond(8'd5);
        assertions++; if (err !== 1'b0 || outstanding !== 3'd0) begin failures++; $display("FAIL unexp_tail: got err=%0b cnt=%0d expected err=0 cnt=0", err, outstanding); end
    endtask

    task automatic test_drain_hold();
        host_bus.h2d.a_valid  = 1'b1;
        host_bus.h2d.a_source = 8'd9;
        dev_bus.d2h.a_ready   = 1'b0;
        step();
        assertions++; if (idle !== 1'b0) begin failures++; $display("FAIL drain_pend_idle: got %0b expected 0", idle); end
        drain = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            assertions++;
            if (dev_bus.h2d.a_valid !== 1'b1) begin failures++; $display("FAIL drain_hold[%0d]: got %0b expected 1", i, dev_bus.h2d.a_valid); end
            step();
        end
        dev_bus.d2h.a_ready = 1'b1;
        #1;
        assertions++; if (host_bus.d2h.a_ready !== 1'b1) begin failures++; $display("FAIL drain_accept: got %0b expected 1", host_bus.d2h.a_ready); end
        step();
        $display("drain: held beat accepted outstanding=%0d", outstanding);
        host_bus.h2d.a_source = 8'd10;
        assertions++; if (dev_bus.h2d.a_valid !== 1'b0 || host_bus.d2h.a_ready !== 1'b0) begin
            failures++; $display("FAIL drain_block: got valid=%0b ready=%0b expected 0 0", dev_bus.h2d.a_valid, host_bus.d2h.a_ready);
        end
        step();
        host_bus.h2d.a_valid = 1'b0;
        assertions++; if (outstanding !== 3'd1) begin failures++; $display("FAIL drain_cnt: got %0d expected 1", outstanding); end
        assertions++; if (idle !== 1'b0) begin failures++; $display("FAIL drain_busy: got %0b expected 0", idle); end
        respond(8'd9);
        assertions++; if (idle !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL drain_idle: got idle=%0b err=%0b expected 1 0", idle, err); end
        drain = 1'b0;
    endtask

    task automatic test_reset_midflight();
        send(8'd1);
        send(8'd2);
        respond(8'd9);
        send(8'd3);
        assertions++; if (outstanding !== 3'd2 || err !== 1'b1) begin failures++; $display("FAIL mid_pre: got cnt=%0d err=%0b expected 2 1", outstanding, err); end
        #1 rst_ni = 1'b0;
        #1;
        assertions++; if (outstanding !== 3'd0) begin failures++; $display("FAIL mid_cnt: got %0d expected 0", outstanding); end
        assertions++; if (idle !== 1'b1) begin failures++; $display("FAIL mid_idle: got %0b expected 1", idle); end
        assertions++; if (err !== 1'b0) begin failures++; $display("FAIL mid_err: got %0b expected 0", err); end
        step();
        rst_ni = 1'b1;
        step();
        err_clr = 1'b1;
        respond(8'd2);
        err_clr = 1'b0;
        assertions++; if (err !== 1'b1) begin failures++; $display("FAIL mid_stale: got %0b expected 1", err); end
        assertions++; if (outstanding !== 3'd0) begin failures++; $display("FAIL mid_stale_cnt: got %0d expected 0", outstanding); end
        pulse_clr();
        assertions++; if (err !== 1'b0) begin failures++; $display("FAIL mid_clr: got %0b expected 0", err); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_in_order();
        test_mismatch();
        test_unexpected();
        test_drain_hold();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
